pll_reset_ctrl: RTL and testbench



---
 rtl/pll_reset_pkg.sv | 24 ++
 rtl/pll_reset_ctrl_sync_2ff.sv | 36 +++
 rtl/pll_reset_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_pkg
// Shared definitions for the PLL reset sequencer: the sequencer state
// encoding and a helper that sizes a counter to hold 0..max_val.
// ---------------------------------------------------------------------------
package pll_reset_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_state_e;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for signals crossing into the clk domain.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low clear (both stages cleared to 0)
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage 0: first capture, may be metastable
      sync_p0 <= d;
      // stage 1: settled value
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
// Supervises a PLL from the free-running reference clock: pulses the PLL
// reset, filters the lock indication, then releases the domain resets in
// staggered order. Lock loss re-asserts every domain reset and re-runs the
// sequence; repeated failed attempts end in a sticky FAULT.
// Ports:
//   clk          - free-running reference clock (not a PLL output)
//   reset_n      - asynchronous active-low reset
//   pll_locked   - raw PLL lock, asynchronous to clk
//   force_relock - synchronous pulse: restart from RESET_PLL, clear FAULT
//   pll_rst      - active-high PLL reset
//   domain_rst_n - active-low domain resets, bit 0 released first
//   ready        - high only in RUN
//   fault        - high only in FAULT
//   relock_count - saturating count of lock losses seen in RUN
// ---------------------------------------------------------------------------
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int NUM_OUT      = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_FILTER  = 1024,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               force_relock,
  output logic               pll_rst,
  output logic [NUM_OUT-1:0] domain_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [7:0]         relock_count
);

  // Elapsed RELEASE cycles at which the last domain bit is released.
  localparam int REL_LAST = STAGGER * (NUM_OUT - 1);
  localparam int RST_W    = cnt_w(RST_CYCLES);
  localparam int TMO_W    = cnt_w(LOCK_TIMEOUT);
  localparam int FLT_W    = cnt_w(LOCK_FILTER);
  localparam int REL_W    = cnt_w(REL_LAST + 1);
  localparam int RTY_W    = cnt_w(MAX_RETRIES);

  logic lock_s;

  pll_state_e         state_q,    state_nx;
  logic [RST_W-1:0]   rst_tmr_q,  rst_tmr_nx;
  logic [TMO_W-1:0]   lock_tmr_q, lock_tmr_nx;
  logic [FLT_W-1:0]   filt_q,     filt_nx;
  logic [REL_W-1:0]   rel_q,      rel_nx;
  logic [RTY_W-1:0]   retry_q,    retry_nx;
  logic [7:0]         relock_q,   relock_nx;
  logic               pll_rst_q,  pll_rst_nx;
  logic [NUM_OUT-1:0] dom_q,      dom_nx;
  logic               ready_q,    ready_nx;
  logic               fault_q,    fault_nx;
  logic               fail;
  logic               timeout;
  int                 rel_elapsed;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d    (pll_locked),
    .q    (lock_s)
  );

  always_comb begin
    state_nx    = state_q;
    rst_tmr_nx  = rst_tmr_q;
    lock_tmr_nx = lock_tmr_q;
    filt_nx     = filt_q;
    rel_nx      = rel_q;
    retry_nx    = retry_q;
    relock_nx   = relock_q;
    pll_rst_nx  = pll_rst_q;
    dom_nx      = dom_q;
    ready_nx    = 1'b0;
    fault_nx    = 1'b0;
    fail        = 1'b0;
    rel_elapsed = int'(rel_q) + 1;
    // The timeout spans WAIT_LOCK and FILTER together, so the timer is
    // never cleared by a lock glitch.
    timeout     = (int'(lock_tmr_q) >= LOCK_TIMEOUT - 1);

    if (force_relock) begin
      state_nx   = RESET_PLL;
      rst_tmr_nx = '0;
      retry_nx   = '0;
      pll_rst_nx = 1'b1;
      dom_nx     = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          pll_rst_nx = 1'b1;
          dom_nx     = '0;
          if (int'(rst_tmr_q) >= RST_CYCLES - 1) begin
            state_nx    = WAIT_LOCK;
            pll_rst_nx  = 1'b0;
            lock_tmr_nx = '0;
            filt_nx     = '0;
          end else begin
            rst_tmr_nx = rst_tmr_q + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (timeout) begin
            fail = 1'b1;
          end else begin
            lock_tmr_nx = lock_tmr_q + 1'b1;
            if (lock_s) begin
              state_nx = FILTER;
              filt_nx  = '0;
            end
          end
        end

        FILTER: begin
          // The lock sample that moved us out of WAIT_LOCK is the first of
          // the LOCK_FILTER consecutive samples, hence the +2.
          if (lock_s && (int'(filt_q) + 2 >= LOCK_FILTER)) begin
            state_nx = RELEASE;
            rel_nx   = '0;
            dom_nx   = '0;
            dom_nx[0] = 1'b1;
          end else if (timeout) begin
            fail = 1'b1;
          end else begin
            lock_tmr_nx = lock_tmr_q + 1'b1;
            if (lock_s) begin
              filt_nx = filt_q + 1'b1;
            end else begin
              state_nx = WAIT_LOCK;
              filt_nx  = '0;
            end
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            fail = 1'b1;
          end else begin
            rel_nx = REL_W'(rel_elapsed);
            for (int i = 0; i < NUM_OUT; i++) begin
              if (STAGGER * i <= rel_elapsed) dom_nx[i] = 1'b1;
            end
            if (rel_elapsed >= REL_LAST + 1) begin
              state_nx = RUN;
              ready_nx = 1'b1;
              retry_nx = '0;
            end
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_nx   = RESET_PLL;
            rst_tmr_nx = '0;
            retry_nx   = '0;
            pll_rst_nx = 1'b1;
            dom_nx     = '0;
            if (relock_q != 8'hFF) relock_nx = relock_q + 8'd1;
          end else begin
            ready_nx = 1'b1;
          end
        end

        FAULT: begin
          pll_rst_nx = 1'b1;
          dom_nx     = '0;
          fault_nx   = 1'b1;
        end

        default: begin
          state_nx   = RESET_PLL;
          rst_tmr_nx = '0;
          pll_rst_nx = 1'b1;
          dom_nx     = '0;
        end
      endcase

      if (fail) begin
        pll_rst_nx = 1'b1;
        dom_nx     = '0;
        rst_tmr_nx = '0;
        if (int'(retry_q) < MAX_RETRIES) begin
          state_nx = RESET_PLL;
          retry_nx = retry_q + 1'b1;
        end else begin
          state_nx = FAULT;
          fault_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_PLL;
      rst_tmr_q  <= '0;
      lock_tmr_q <= '0;
      filt_q     <= '0;
      rel_q      <= '0;
      retry_q    <= '0;
      relock_q   <= '0;
      pll_rst_q  <= 1'b1;
      dom_q      <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_nx;
      rst_tmr_q  <= rst_tmr_nx;
      lock_tmr_q <= lock_tmr_nx;
      filt_q     <= filt_nx;
      rel_q      <= rel_nx;
      retry_q    <= retry_nx;
      relock_q   <= relock_nx;
      pll_rst_q  <= pll_rst_nx;
      dom_q      <= dom_nx;
      ready_q    <= ready_nx;
      fault_q    <= fault_nx;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = dom_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_ctrl
// Scoreboard bench: each stimulus step pushes the output changes it should
// cause ({pll_rst, domain_rst_n[2:0], ready, fault} and the clk cycle of the
// change); a negedge monitor pops and compares every observed change.
// ---------------------------------------------------------------------------
module tb_pll_reset_ctrl;

  localparam int NUM_OUT = 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               pll_locked = 1'b0;
  logic               force_relock = 1'b0;
  logic               pll_rst;
  logic [NUM_OUT-1:0] domain_rst_n;
  logic               ready;
  logic               fault;
  logic [7:0]         relock_count;

  pll_reset_ctrl #(
    .NUM_OUT     (NUM_OUT),
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(100),
    .LOCK_FILTER (10),
    .STAGGER     (5),
    .MAX_RETRIES (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .domain_rst_n(domain_rst_n),
    .ready       (ready),
    .fault       (fault),
    .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  typedef struct {
    string      tag;
    int         cyc;
    logic [5:0] val;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] prev = 6'b100000;
  logic [5:0] obs;
  bit         mon_en = 1'b0;

  // Output-change monitor: every change while enabled must match the head
  // of the scoreboard, both in value and in the cycle it appeared.
  always @(negedge clk) begin
    obs = {pll_rst, domain_rst_n, ready, fault};
    if (mon_en && obs !== prev) begin
      if (sb_q.size() == 0) begin
        chk_eq("spurious_change", int'(obs), int'(prev));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk_eq({e.tag, "_val"}, int'(obs), int'(e.val));
        chk_eq({e.tag, "_cyc"}, cyc, e.cyc);
      end
    end
    prev = obs;
  end

  task automatic push(input string tag, input int c, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = c;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_drained"}, sb_q.size(), 0);
  endtask

  // Pushes a release sequence whose bit 0 comes up at cycle r.
  task automatic push_release(input string tag, input int r);
    push({tag, "_b0"},  r,      6'b000100);
    push({tag, "_b1"},  r + 5,  6'b001100);
    push({tag, "_b2"},  r + 10, 6'b011100);
    push({tag, "_rdy"}, r + 11, 6'b011110);
  endtask

  initial begin
    int c;
    int n;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_outputs", int'({pll_rst, domain_rst_n, ready, fault}), 6'b100000);
    chk_eq("rst_relock", int'(relock_count), 0);

    // clean bring-up: lock rises 20 cycles after reset release
    reset_n = 1'b1;
    c = cyc;
    mon_en = 1'b1;
    push("t1_wait", c + 4, 6'b000000);
    push_release("t1", c + 32);
    to_cyc(c + 20);
    pll_locked = 1'b1;
    drain("t1", 60);
    chk_eq("t1_ready", int'(ready), 1);

    // one-cycle lock loss in RUN
    c = cyc;
    pll_locked = 1'b0;
    push("t2_loss", c + 3, 6'b100000);
    push("t2_wait", c + 7, 6'b000000);
    push_release("t2", c + 17);
    @(negedge clk);
    pll_locked = 1'b1;
    drain("t2", 60);
    chk_eq("t2_relock", int'(relock_count), 1);

    // glitchy lock: 7 high, 1 low, then steady
    c = cyc;
    force_relock = 1'b1;
    pll_locked = 1'b0;
    push("t3_force", c + 1, 6'b100000);
    push("t3_wait", c + 5, 6'b000000);
    push_release("t3", c + 30);
    @(negedge clk);
    force_relock = 1'b0;
    to_cyc(c + 10);
    pll_locked = 1'b1;
    to_cyc(c + 17);
    pll_locked = 1'b0;
    to_cyc(c + 18);
    pll_locked = 1'b1;
    drain("t3", 60);
    chk_eq("t3_relock", int'(relock_count), 1);

    // repeated lock losses until relock_count saturates
    mon_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (5) @(negedge clk);
      n = 0;
      while (!ready && n < 80) begin
        @(negedge clk);
        n++;
      end
      chk_eq("t4_ready", int'(ready), 1);
      if (i == 99) chk_eq("t4_relock_mid", int'(relock_count), 101);
    end
    chk_eq("t4_relock_sat", int'(relock_count), 255);
    @(negedge clk);
    mon_en = 1'b1;

    // never locks: three PLL reset pulses 104 cycles apart, then FAULT
    c = cyc;
    force_relock = 1'b1;
    pll_locked = 1'b0;
    push("t5_p1", c + 1,   6'b100000);
    push("t5_w1", c + 5,   6'b000000);
    push("t5_p2", c + 105, 6'b100000);
    push("t5_w2", c + 109, 6'b000000);
    push("t5_p3", c + 209, 6'b100000);
    push("t5_w3", c + 213, 6'b000000);
    push("t5_fault", c + 313, 6'b100001);
    @(negedge clk);
    force_relock = 1'b0;
    drain("t5", 400);
    repeat (200) @(negedge clk);
    chk_eq("t5_fault_held", int'(fault), 1);
    chk_eq("t5_pll_rst_held", int'(pll_rst), 1);
    chk_eq("t5_dom_held", int'(domain_rst_n), 0);

    // force_relock leaves FAULT and sequences to ready
    c = cyc;
    force_relock = 1'b1;
    pll_locked = 1'b1;
    push("t6_force", c + 1, 6'b100000);
    push("t6_wait", c + 5, 6'b000000);
    push_release("t6", c + 15);
    @(negedge clk);
    force_relock = 1'b0;
    drain("t6", 60);
    chk_eq("t6_relock", int'(relock_count), 255);

    // asynchronous reset while domain_rst_n = 001
    c = cyc;
    force_relock = 1'b1;
    push("t7_force", c + 1, 6'b100000);
    push("t7_wait", c + 5, 6'b000000);
    push("t7_b0", c + 15, 6'b000100);
    @(negedge clk);
    force_relock = 1'b0;
    drain("t7", 30);
    chk_eq("t7_pre_dom", int'(domain_rst_n), 1);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_eq("t7_async_outputs", int'({pll_rst, domain_rst_n, ready, fault}), 6'b100000);
    chk_eq("t7_async_relock", int'(relock_count), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    c = cyc;
    mon_en = 1'b1;
    push("t7_rwait", c + 4, 6'b000000);
    push_release("t7r", c + 14);
    drain("t7r", 60);
    chk_eq("t7_ready", int'(ready), 1);

    repeat (10) @(negedge clk);
    chk_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
